adder_serial_nbit: RTL
======================

Name: adder_serial_nbit

Overview:
- Multi-cycle, parametrised two's-complement adder/subtractor for the cpu15 datapath. Successor to the fixed 4-bit combinational adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, through one shared CHUNK-bit adder slice with a registered carry.
- Uses a start/busy/done handshake, so the ALU trades latency for area at wider datapaths.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE.
- sub  input  1  0 = a+b+cin; 1 = a-b (b inverted, carry-in forced 1, cin ignored); latched at accept.
- cin  input  1  carry-in for add mode; latched at accept.
- a  input  WIDTH  operand A; latched at accept.
- b  input  WIDTH  operand B; latched at accept.
- s  output  WIDTH  result; registered; changes only on completion.
- cout  output  1  carry out of the MSB (sub mode: 1 = no borrow); registered.
- ovf  output  1  signed overflow; registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking new s/cout/ovf.

Behaviour:
- Clock and reset: one clock, clk. Reset n_reset is asynchronous and active-low.
- Reset values: s=0, cout=0, ovf=0, busy=0, done=0, state=IDLE, chunk counter=0, carry register=0.
- Reset mid-operation aborts the operation immediately and restores the reset values.
- States:
  - IDLE: start=1 -> latch a, b' (b, or ~b when sub=1), carry (cin, or 1 when sub=1), zero the counter, go to RUN, busy=1.
  - RUN: each edge adds chunk[k] of a and b' plus the carry register, writes sum chunk k into the internal accumulator, updates the carry, and increments k.
  - RUN exit: after the edge processing k=NCHUNK-1, copy the accumulator to s, the final carry to cout, and the overflow to ovf; set done=1, busy=0; go to DONE.
  - DONE: lasts exactly one cycle. start=1 -> accept exactly as in IDLE (back-to-back); otherwise go to IDLE. done returns to 0 on the next edge either way.
- Latency: done is high in the cycle NCHUNK edges after the accepting edge. Issue interval is NCHUNK+1 cycles. CHUNK=WIDTH gives latency 1.
- start while in RUN is ignored; operand changes after accept have no effect.
- ovf = (a[MSB] == b'[MSB]) && (s[MSB] != a[MSB]), evaluated on the final sum.
- s/cout/ovf hold their last result through IDLE and RUN until the next completion.
- The counter wraps only via the RUN->DONE transition; no modulo arithmetic beyond NCHUNK-1.
- All outputs are direct register outputs; no combinational path from any input to any output.

Decomposition:
- Shared package (cpu15_pkg): state encodings ST_IDLE, ST_RUN, ST_DONE (2-bit); width helper for the counter, clog2 of NCHUNK with a minimum of 1.
- Sub-module adder_chunk: combinational CHUNK-bit ripple adder (x, y, ci -> sum, co), parametrised by CHUNK.
- Top level holds the FSM, counter, operand shift/index logic, accumulator and output registers.

Test Plan:
- WIDTH=16/CHUNK=4: a=0x1234, b=0x0001, sub=0, cin=0, start -> done exactly 4 cycles after accept; s=0x1235, cout=0, ovf=0; busy high for cycles 1..3.
- Carry and overflow: 0xFFFF+0x0001 -> s=0x0000, cout=1, ovf=0. 0x7FFF+0x0001 -> s=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0008, sub=1 -> s=0xFFFD, cout=0, ovf=0. Then 0x8000-0x0001 -> s=0x7FFF, cout=1, ovf=1.
- Handshake: start held high continuously -> accepts every 5 cycles. A start pulse during RUN with different operands is ignored; the result matches the first operands.
- Reset: assert n_reset at RUN cycle 2 -> outputs zero immediately. A fresh start after release gives the correct result, with no stale carry.
- WIDTH=4/CHUNK=1 sequence (0+0, 0+1, 1+1, 1+2, 2+3, 3+5, 5+8, 8+D) -> {cout,s} = 00,01,02,03,05,08,0D,15 with latency 4. Same sequence with CHUNK=4 -> latency 1.

Source files
------------

// File: rtl/adder_serial_nbit_pkg.sv
// Shared definitions for the cpu15 serial adder: FSM encodings and
// the counter-width helper used to size the chunk index.
package cpu15_pkg;

    // FSM encodings, kept as plain 2-bit constants so older blocks can reuse them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits needed to count 0..n-1. The result is never zero, so a
    // single-chunk configuration still gets a legal 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice. The serial adder
// reuses this one slice for every chunk of the operands.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/adder_serial_nbit.sv
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operand pair
// is added CHUNK bits per clock, LSB chunk first, through one shared slice
// with a registered carry. A start/busy/done handshake frames each operation.
module adder_serial_nbit
    import cpu15_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;      // shifts right one chunk per RUN edge
    logic [WIDTH-1:0] op_b;      // b or ~b, shifted the same way
    logic [WIDTH-1:0] acc;       // sum chunks enter at the top, shift down
    logic [WIDTH-1:0] acc_next;
    logic             carry;

    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] sum;
    logic             co;

    logic accept;
    logic run;
    logic last;
    logic ovf_next;

    // Start is honoured only when no operation is in flight.
    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign run    = (state == ST_RUN);
    assign last   = (cnt == CW'(NCHUNK - 1));

    // The operand registers shift, so the active chunk is always the low chunk.
    assign x = op_a[CHUNK-1:0];
    assign y = op_b[CHUNK-1:0];

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_slice (
        .x   (x),
        .y   (y),
        .ci  (carry),
        .sum (sum),
        .co  (co)
    );

    // After NCHUNK shifts, the first chunk has reached bit 0 and the last
    // chunk occupies the MSBs, so acc_next holds the full result on the last edge.
    assign acc_next = (acc >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));

    // On the last chunk, x/y top bits are the operand MSBs and sum's top bit
    // is the result MSB. Overflow can therefore be derived from the slice alone.
    assign ovf_next = (x[CHUNK-1] == y[CHUNK-1]) && (sum[CHUNK-1] != x[CHUNK-1]);

    // Control FSM: state, chunk counter and handshake flags.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: latch operands on accept, then consume one chunk per RUN edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub | cin;       // subtract forces carry-in to 1
        end else if (run) begin
            op_a  <= op_a >> CHUNK;
            op_b  <= op_b >> CHUNK;
            acc   <= acc_next;
            carry <= co;
        end
    end

    // Result registers: updated only on completion, held otherwise.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (run && last) begin
            s    <= acc_next;
            cout <= co;
            ovf  <= ovf_next;
        end
    end

endmodule
